// File: rtl/dmem_arbiter_if.sv
// Buses around the data-memory arbiter: one requester port type and the memory port.

interface dmem_port_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              wren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] q;

   // Requester side drives the command, arbiter side answers with grant/read data.
   modport master (output req, wren, addr, data, input gnt, rvalid, q);
   modport slave  (input req, wren, addr, data, output gnt, rvalid, q);
endinterface

interface dmem_mem_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic [DATA_W-1:0] q;

   // Arbiter issues commands, the syncram returns q.
   modport master (output address, data, wren, input q);
   modport slave  (input address, data, wren, output q);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data syncram between the
// processor port (p) and the DMA/debug port (d). Commands are registered
// onto the memory bus; a tag pipeline routes each read result back to its issuer.

module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned READ_LAT = 1
) (
   input logic         clock,
   input logic         reset,
   dmem_port_if.slave  p,
   dmem_port_if.slave  d,
   dmem_mem_if.master  mem
);

   localparam int unsigned TAG_D = READ_LAT + 1;

   typedef enum logic {
      OWN_P = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   owner_e            last_owner;
   logic              p_win_c;
   logic              d_win_c;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wren_q;
   // One valid bit per owner per stage, so each rvalid is a plain flop output.
   logic [TAG_D-1:0]  p_tag;
   logic [TAG_D-1:0]  d_tag;

   // Round-robin grant: on a tie the port that did not win last time goes first.
   always_comb begin
      p_win_c = 1'b0;
      d_win_c = 1'b0;
      if (reset) begin
         if (p.req && (!d.req || last_owner == OWN_D)) begin
            p_win_c = 1'b1;
         end else if (d.req) begin
            d_win_c = 1'b1;
         end
      end
   end

   assign p.gnt = p_win_c;
   assign d.gnt = d_win_c;

   // Issue stage: register the winner's command; address/data hold when idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         last_owner <= OWN_D;
      end else begin
         wren_q <= 1'b0;
         if (p_win_c) begin
            addr_q     <= p.addr;
            data_q     <= p.data;
            wren_q     <= p.wren;
            last_owner <= OWN_P;
         end else if (d_win_c) begin
            addr_q     <= d.addr;
            data_q     <= d.data;
            wren_q     <= d.wren;
            last_owner <= OWN_D;
         end
      end
   end

   assign mem.address = addr_q;
   assign mem.data    = data_q;
   assign mem.wren    = wren_q;

   // Read tag pipeline: a read tag enters at accept and surfaces when mem.q is valid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_tag <= '0;
         d_tag <= '0;
      end else begin
         p_tag <= {p_tag[TAG_D-2:0], p_win_c & ~p.wren};
         d_tag <= {d_tag[TAG_D-2:0], d_win_c & ~d.wren};
      end
   end

   assign p.rvalid = p_tag[TAG_D-1];
   assign d.rvalid = d_tag[TAG_D-1];

   // Both requesters see the raw memory output and qualify it with their rvalid.
   assign p.q = mem.q;
   assign d.q = mem.q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LAT 1 and 2) driven by the same
// requester stimulus, each with its own syncram model and read scoreboard.
`timescale 1ns/1ps

module tb_dmem_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic          p_req, p_wren, d_req, d_wren;
   logic [AW-1:0] p_addr, d_addr;
   logic [DW-1:0] p_data, d_data;

   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) d1 ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p2 ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) d2 ();
   dmem_mem_if  #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
   dmem_mem_if  #(.ADDR_W(AW), .DATA_W(DW)) m2 ();

   assign p1.req = p_req;  assign p1.wren = p_wren;  assign p1.addr = p_addr;  assign p1.data = p_data;
   assign p2.req = p_req;  assign p2.wren = p_wren;  assign p2.addr = p_addr;  assign p2.data = p_data;
   assign d1.req = d_req;  assign d1.wren = d_wren;  assign d1.addr = d_addr;  assign d1.data = d_data;
   assign d2.req = d_req;  assign d2.wren = d_wren;  assign d2.addr = d_addr;  assign d2.data = d_data;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
      .clock(clock), .reset(reset), .p(p1), .d(d1), .mem(m1));
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_dut2 (
      .clock(clock), .reset(reset), .p(p2), .d(d2), .mem(m2));

   // Syncram models: word i initialised to 0xC0DE0000 | i.
   logic [DW-1:0] mem1 [0:4095];
   logic [DW-1:0] mem2 [0:4095];
   logic [DW-1:0] q1, q2a, q2b;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem1[i] = 32'hC0DE0000 | 32'(i);
         mem2[i] = 32'hC0DE0000 | 32'(i);
      end
   end

   always @(posedge clock) begin
      if (m1.wren) mem1[m1.address] <= m1.data;
      q1 <= mem1[m1.address];
      if (m2.wren) mem2[m2.address] <= m2.data;
      q2a <= mem2[m2.address];
      q2b <= q2a;
   end
   assign m1.q = q1;
   assign m2.q = q2b;

   // Scoreboard entries.
   typedef struct {
      bit            own_d;
      logic [DW-1:0] q;
      int            due;
   } rd_t;
   typedef struct {
      logic          wren;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } cmd_t;

   rd_t  rq1[$];
   rd_t  rq2[$];
   cmd_t cq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Read-return monitor for one instance.
   task automatic mon_rd(input bit second, input logic pv, input logic dv,
                         input logic [DW-1:0] pq, input logic [DW-1:0] dq);
      rd_t   e;
      bit    have;
      string tag;
      tag  = second ? "lat2" : "lat1";
      have = second ? (rq2.size() != 0) : (rq1.size() != 0);
      if (pv || dv) begin
         if (!have) begin
            check($sformatf("%s unexpected rvalid", tag), 32'({pv, dv}), 32'h0);
         end else begin
            if (second) e = rq2.pop_front(); else e = rq1.pop_front();
            check($sformatf("%s rvalid owner {p,d}", tag), 32'({pv, dv}), e.own_d ? 32'h1 : 32'h2);
            check($sformatf("%s rvalid cycle", tag), 32'(cyc), 32'(e.due));
            check($sformatf("%s read data", tag), e.own_d ? dq : pq, e.q);
         end
      end else if (have) begin
         if (second) e = rq2[0]; else e = rq1[0];
         if (e.due < cyc) begin
            check($sformatf("%s missing rvalid, cycle now vs due", tag), 32'(cyc), 32'(e.due));
            if (second) void'(rq2.pop_front()); else void'(rq1.pop_front());
         end
      end
   endtask

   // Monitor: read returns per instance, memory commands on both instances.
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         mon_rd(1'b0, p1.rvalid, d1.rvalid, p1.q, d1.q);
         mon_rd(1'b1, p2.rvalid, d2.rvalid, p2.q, d2.q);
         if (cq.size() != 0 && cq[0].due == cyc) begin
            cmd_t c;
            c = cq.pop_front();
            check("lat1 mem_address", 32'(m1.address), 32'(c.addr));
            check("lat2 mem_address", 32'(m2.address), 32'(c.addr));
            check("lat1 mem_wren", 32'(m1.wren), 32'(c.wren));
            check("lat2 mem_wren", 32'(m2.wren), 32'(c.wren));
            check("lat1 mem_data", m1.data, c.data);
            check("lat2 mem_data", m2.data, c.data);
         end else if (m1.wren || m2.wren) begin
            check("unexpected mem_wren {lat1,lat2}", 32'({m1.wren, m2.wren}), 32'h0);
         end
      end
   end

   // Drive one request and hold it until granted; queue the expected outcome.
   task automatic op(input bit is_d, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] eq, output int g);
      int n;
      n = 0;
      g = -1;
      if (is_d) begin d_req = 1'b1; d_wren = wr; d_addr = a; d_data = wd; end
      else      begin p_req = 1'b1; p_wren = wr; p_addr = a; p_data = wd; end
      while (g < 0 && n < 20) begin
         @(negedge clock);
         if ((is_d ? d1.gnt : p1.gnt) === 1'b1) g = cyc;
         n++;
      end
      if (g < 0) begin
         checks++;
         errors++;
         $display("FAIL %s grant timeout: gnt stayed 0 for 20 cycles, required 1", is_d ? "d" : "p");
      end else begin
         cq.push_back('{wr, a, wd, g + 1});
         if (!wr) begin
            rq1.push_back('{is_d, eq, g + 2});
            rq2.push_back('{is_d, eq, g + 3});
         end
         @(posedge clock);
         #1;
      end
      if (is_d) d_req = 1'b0; else p_req = 1'b0;
   endtask

   task automatic do_reset();
      p_req = 1'b0;
      d_req = 1'b0;
      reset = 1'b0;
      rq1.delete(); rq2.delete(); cq.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic drain();
      repeat (6) @(posedge clock);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, g1, g2, s;
      logic [AW-1:0] t2_addr [4];
      logic [DW-1:0] t2_exp  [4];
      t2_addr = '{12'h100, 12'h201, 12'h102, 12'h203};
      t2_exp  = '{32'hC0DE0100, 32'hC0DE0201, 32'hC0DE0102, 32'hC0DE0203};
      p_wren = 1'b0; d_wren = 1'b0; p_addr = '0; d_addr = '0; p_data = '0; d_data = '0;
      p_req = 1'b0; d_req = 1'b0;
      reset = 1'b0;
      #1;
      // Reset state with both requests up: no grant, idle memory bus.
      p_req = 1'b1; d_req = 1'b1;
      #1;
      check("reset p_gnt/d_gnt", 32'({p1.gnt, d1.gnt, p2.gnt, d2.gnt}), 32'h0);
      check("reset mem_address", 32'(m1.address), 32'h0);
      check("reset mem_data", m1.data, 32'h0);
      check("reset mem_wren", 32'({m1.wren, m2.wren}), 32'h0);
      check("reset rvalids", 32'({p1.rvalid, d1.rvalid, p2.rvalid, d2.rvalid}), 32'h0);

      // Single P read straight after reset.
      do_reset();
      s = cyc;
      op(1'b0, 1'b0, 12'h010, 32'h0, 32'hC0DE0010, g0);
      check("single read granted in first cycle", 32'(g0), 32'(s));
      drain();

      // Continuous contention from reset: P, D, P, D.
      do_reset();
      p_req = 1'b1; p_wren = 1'b0; p_addr = t2_addr[0]; p_data = 32'h0;
      d_req = 1'b1; d_wren = 1'b0; d_addr = t2_addr[1]; d_data = 32'h11111111;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check($sformatf("contention k=%0d p_gnt", k), 32'(p1.gnt), 32'(k % 2 == 0));
         check($sformatf("contention k=%0d d_gnt", k), 32'(d1.gnt), 32'(k % 2 == 1));
         cq.push_back('{1'b0, t2_addr[k], (k % 2 == 1) ? 32'h11111111 : 32'h0, cyc + 1});
         rq1.push_back('{(k % 2 == 1), t2_exp[k], cyc + 2});
         rq2.push_back('{(k % 2 == 1), t2_exp[k], cyc + 3});
         @(posedge clock);
         #1;
         if (k + 2 < 4) begin
            if (k % 2 == 0) p_addr = t2_addr[k + 2]; else d_addr = t2_addr[k + 2];
         end
      end
      p_req = 1'b0; d_req = 1'b0;
      drain();

      // D writes, then P reads the same word back.
      op(1'b1, 1'b1, 12'h020, 32'hDEADBEEF, 32'h0, g0);
      op(1'b0, 1'b0, 12'h020, 32'h0, 32'hDEADBEEF, g1);
      check("read after write granted next cycle", 32'(g1), 32'(g0 + 1));
      drain();

      // Interleaved reads P@1, D@2, P@3 back to back.
      fork
         begin
            op(1'b0, 1'b0, 12'h001, 32'h0, 32'hC0DE0001, g0);
            op(1'b0, 1'b0, 12'h003, 32'h0, 32'hC0DE0003, g2);
         end
         begin
            @(posedge clock);
            #1;
            op(1'b1, 1'b0, 12'h002, 32'h0, 32'hC0DE0002, g1);
         end
      join
      check("interleave D after first P", 32'(g1), 32'(g0 + 1));
      check("interleave second P after D", 32'(g2), 32'(g1 + 1));
      drain();

      // Reset with two reads in flight; requests held high through reset.
      fork
         op(1'b0, 1'b0, 12'h030, 32'h0, 32'hC0DE0030, g0);
         op(1'b1, 1'b0, 12'h040, 32'h0, 32'hC0DE0040, g1);
      join
      reset = 1'b0;
      rq1.delete(); rq2.delete(); cq.delete();
      p_req = 1'b1; d_req = 1'b1;
      #1;
      check("mid reset gnts", 32'({p1.gnt, d1.gnt, p2.gnt, d2.gnt}), 32'h0);
      check("mid reset rvalids", 32'({p1.rvalid, d1.rvalid, p2.rvalid, d2.rvalid}), 32'h0);
      check("mid reset mem_wren", 32'({m1.wren, m2.wren}), 32'h0);
      check("mid reset lat1 mem_address", 32'(m1.address), 32'h0);
      check("mid reset lat2 mem_address", 32'(m2.address), 32'h0);
      repeat (3) @(posedge clock);
      #1;
      p_req = 1'b0; d_req = 1'b0;
      reset = 1'b1;
      fork
         op(1'b0, 1'b0, 12'h050, 32'h0, 32'hC0DE0050, g0);
         op(1'b1, 1'b0, 12'h060, 32'h0, 32'hC0DE0060, g1);
      join
      check("tie after reset goes to P, D next", 32'(g1), 32'(g0 + 1));
      drain();

      // Idle: nothing granted, bus holds the last address with no writes.
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check("idle gnts", 32'({p1.gnt, d1.gnt, p2.gnt, d2.gnt}), 32'h0);
         check("idle rvalids", 32'({p1.rvalid, d1.rvalid, p2.rvalid, d2.rvalid}), 32'h0);
         check("idle mem_wren", 32'({m1.wren, m2.wren}), 32'h0);
         check("idle mem_address hold", 32'({m1.address, m2.address}), 32'h060060);
      end

      check("lat1 reads outstanding at end", 32'(rq1.size()), 32'h0);
      check("lat2 reads outstanding at end", 32'(rq2.size()), 32'h0);
      check("commands outstanding at end", 32'(cq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the processor load/store port (P) and a DMA/debug port (D).
- Sits between the processor dmem outputs and the dmem syncram.
- Registers every memory command and tracks outstanding reads so each read result returns only to the requester that issued it.
- Arbitration is round-robin. One command is accepted per cycle.

Parameters:
- ADDR_W, 12, memory word-address width.
- DATA_W, 32, data width.
- READ_LAT, 1, cycles from command on mem_* outputs to valid mem_q (syncram output latency, 1..4).

Ports:
- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- p_req  in  1  processor request; held until p_gnt
- p_wren  in  1  processor write (1) / read (0); qualified by p_req
- p_addr  in  ADDR_W  processor address
- p_data  in  DATA_W  processor write data
- p_gnt  out  1  one-cycle pulse: P request accepted this cycle
- p_rvalid  out  1  one-cycle pulse: p_q holds read data for P
- p_q  out  DATA_W  read data to P
- d_req, d_wren, d_addr, d_data  in  1/1/ADDR_W/DATA_W  DMA request fields, same rules as P
- d_gnt, d_rvalid  out  1/1  DMA grant and read-valid pulses
- d_q  out  DATA_W  read data to D
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  from dmem q

Behaviour:
- Reset (reset=0, asynchronous):
  - p_gnt, d_gnt, p_rvalid, d_rvalid, mem_wren = 0.
  - mem_address and mem_data = 0.
  - Read tag pipeline cleared.
  - last_owner = D, so P wins the first tie.
- Grant logic is combinational from req and last_owner:
  - Only P requesting: p_gnt=1.
  - Only D requesting: d_gnt=1.
  - Both requesting: grant the port that is not last_owner.
  - Neither requesting: no grant.
  - At most one gnt is high per cycle.
  - gnt is forced to 0 while reset is asserted.
- A request counts as accepted on the rising edge where req and gnt are both 1.
  - A requester must hold req, wren, addr and data stable until it sees gnt.
  - It may deassert req, or present a new request, in the following cycle.
- Issue stage, on an accepted edge:
  - mem_address, mem_data and mem_wren are registered from the winner's fields.
  - last_owner updates to the winner.
  - With no accept, mem_wren is registered 0 and mem_address/mem_data hold their previous values.
  - Commands therefore appear on mem_* exactly 1 cycle after the grant cycle.
- Throughput and fairness:
  - Back-to-back accepts are allowed: one command per cycle.
  - Under continuous contention, grants alternate P, D, P, D…
  - A waiting requester waits at most 1 cycle behind the other.
- Read return:
  - A tag shift register READ_LAT+1 stages deep carries {valid, owner} for each accepted read. Writes insert valid=0.
  - The tag enters at accept and emerges at edge accept+1+READ_LAT.
  - When an emerging tag is valid, pulse the matching rvalid for 1 cycle.
  - Read latency, grant cycle to rvalid cycle, is READ_LAT+1 cycles.
  - p_q and d_q are both wired directly to mem_q; consumers qualify the data with their own rvalid.
- Ordering: commands reach memory in grant order. A read issued after a write to the same address returns the written data.
- Reset mid-operation: every in-flight read is dropped; no rvalid is produced for it after reset is released.
- Combinational request-to-memory paths: none. Every mem_* output is a flop output.

Test Plan:
- Reset then single P read, addr=0x010, READ_LAT=1 -> p_gnt in cycle 0; mem_address=0x010 and mem_wren=0 in cycle 1; p_rvalid in cycle 2 with p_q equal to the memory word; d_rvalid stays 0.
- P and D both request from reset -> grant order P, D, P, D over 4 cycles with no gap; last_owner toggles each cycle; each requester waits at most 1 cycle.
- D writes 0xDEADBEEF to 0x020, then P reads 0x020 in the next granted cycle -> mem_wren=1 for exactly one cycle; p_rvalid with p_q=0xDEADBEEF.
- Interleaved reads P@0x1, D@0x2, P@0x3 back-to-back, READ_LAT=2 -> rvalids arrive on consecutive cycles in the order p, d, p, 3 cycles after each grant, each carrying the correct data.
- Assert reset with 2 reads in flight -> outputs clear immediately; after release no rvalid appears; the next tie goes to P.
- No requests for 10 cycles -> mem_wren=0 throughout; mem_address holds its last value; no gnt or rvalid pulses.
